// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scan_debounce : row-scanned keypad front end with press/release
// debounce, multi-key rejection and a one-cycle new-key strobe.
// Revision: 1.0
// ---------------------------------------------------------------------------
module keypad_scan_debounce #(
   parameter int NROWS           = 4,
   parameter int NCOLS           = 4,
   parameter int SCAN_DWELL      = 4,
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NCOLS-1:0]                col_in,
   output logic [NROWS-1:0]                row_drive,
   output logic [NROWS+NCOLS-1:0]          key_code,
   output logic [$clog2(NROWS*NCOLS)-1:0]  key_index,
   output logic                            key_valid,
   output logic                            key_held
);

   localparam int ROW_W   = (NROWS > 1) ? $clog2(NROWS) : 1;
   localparam int COL_W   = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
   localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int IDX_W   = $clog2(NROWS*NCOLS);

   localparam logic [ROW_W-1:0]   c_row_last   = ROW_W'(NROWS-1);
   localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(SCAN_DWELL-1);
   localparam logic [DEB_W-1:0]   c_deb_last   = DEB_W'(DEBOUNCE_CYCLES-1);

   localparam logic [1:0] S_SCAN        = 2'd0;
   localparam logic [1:0] S_DEB_PRESS   = 2'd1;
   localparam logic [1:0] S_HELD        = 2'd2;
   localparam logic [1:0] S_DEB_RELEASE = 2'd3;

   logic [NCOLS-1:0]           r_sync1;
   logic [NCOLS-1:0]           r_sync2;
   logic [1:0]                 r_state;
   logic [1:0]                 w_next_state;
   logic [ROW_W-1:0]           r_row;
   logic [DWELL_W-1:0]         r_dwell;
   logic [DEB_W-1:0]           r_deb;
   logic [NCOLS-1:0]           r_lat_col;
   logic [COL_W-1:0]           r_lat_col_idx;
   logic [NROWS+NCOLS-1:0]     r_key_code;
   logic [IDX_W-1:0]           r_key_index;
   logic                       r_key_valid;

   logic [NCOLS-1:0]           w_col_s;
   logic                       w_col_onehot;
   logic [COL_W-1:0]           w_col_idx;
   logic                       w_match;
   logic                       w_lat_bit;
   logic [ROW_W-1:0]           w_row_next;
   logic                       w_dwell_done;
   logic                       w_deb_done;
   logic [IDX_W-1:0]           w_key_index;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= col_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_col_s      = r_sync2;
   assign w_col_onehot = (w_col_s != '0) && ((w_col_s & (w_col_s - 1'b1)) == '0);
   assign w_match      = (w_col_s == r_lat_col);
   assign w_lat_bit    = |(w_col_s & r_lat_col);
   assign w_row_next   = (r_row == c_row_last) ? '0 : r_row + 1'b1;
   assign w_dwell_done = (r_dwell == c_dwell_last);
   assign w_deb_done   = (r_deb == c_deb_last);
   assign w_key_index  = IDX_W'(int'(r_row) * NCOLS + int'(r_lat_col_idx));

   always_comb begin
      w_col_idx = '0;
      for (int c = 0; c < NCOLS; c++) begin
         if (w_col_s[c]) w_col_idx = COL_W'(c);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_SCAN;
      else       r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_SCAN:        if (w_dwell_done && w_col_onehot) w_next_state = S_DEB_PRESS;
         S_DEB_PRESS:   if (!w_match)                     w_next_state = S_SCAN;
                        else if (w_deb_done)              w_next_state = S_HELD;
         S_HELD:        if (!w_lat_bit)                   w_next_state = S_DEB_RELEASE;
         S_DEB_RELEASE: if (!w_lat_bit && w_deb_done)     w_next_state = S_SCAN;
         default:                                         w_next_state = S_SCAN;
      endcase
   end

   // Counters, latched key and registered outputs; the row pointer stays on
   // the latched row from press detection until release or abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_row         <= '0;
         r_dwell       <= '0;
         r_deb         <= '0;
         r_lat_col     <= '0;
         r_lat_col_idx <= '0;
         r_key_code    <= '0;
         r_key_index   <= '0;
         r_key_valid   <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         case (r_state)
            S_SCAN: begin
               if (w_dwell_done) begin
                  r_dwell <= '0;
                  if (w_col_onehot) begin
                     r_lat_col     <= w_col_s;
                     r_lat_col_idx <= w_col_idx;
                     r_deb         <= '0;
                  end else begin
                     r_row <= w_row_next;
                  end
               end else begin
                  r_dwell <= r_dwell + 1'b1;
               end
            end
            S_DEB_PRESS: begin
               if (!w_match) begin
                  r_row   <= w_row_next;
                  r_dwell <= '0;
               end else if (w_deb_done) begin
                  r_key_valid <= 1'b1;
                  r_key_code  <= {row_drive, r_lat_col};
                  r_key_index <= w_key_index;
               end else begin
                  r_deb <= r_deb + 1'b1;
               end
            end
            S_HELD: begin
               if (!w_lat_bit) r_deb <= '0;
            end
            S_DEB_RELEASE: begin
               if (w_lat_bit) begin
                  r_deb <= '0;
               end else if (w_deb_done) begin
                  r_row   <= w_row_next;
                  r_dwell <= '0;
               end else begin
                  r_deb <= r_deb + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      row_drive = {{(NROWS-1){1'b0}}, 1'b1} << r_row;
      key_held  = (r_state == S_HELD) || (r_state == S_DEB_RELEASE);
      key_code  = r_key_code;
      key_index = r_key_index;
      key_valid = r_key_valid;
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// Scoreboard bench for keypad_scan_debounce: a keypad model drives col_in from
// row_drive, expected accepted keys are queued and checked on each key_valid.
module tb_keypad_scan_debounce;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] col_in;
   logic [3:0] row_drive;
   logic [7:0] key_code;
   logic [3:0] key_index;
   logic       key_valid;
   logic       key_held;

   logic [3:0]  keys [4];
   logic        kill;
   logic [11:0] exp_q [$];
   logic [11:0] e;
   int          checks   = 0;
   int          failures = 0;
   int          pulses   = 0;

   always #5 clk = ~clk;

   keypad_scan_debounce #(
      .NROWS(4), .NCOLS(4), .SCAN_DWELL(3), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .col_in(col_in), .row_drive(row_drive),
      .key_code(key_code), .key_index(key_index), .key_valid(key_valid),
      .key_held(key_held)
   );

   always_comb begin
      col_in = '0;
      for (int r = 0; r < 4; r++) begin
         if (row_drive[r]) col_in = col_in | keys[r];
      end
      if (kill) col_in = '0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every key_valid pulse consumes one expected key
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            check("unexpected_key_valid_queue_depth", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("key_code", 32'(key_code), 32'(e[11:4]));
            check("key_index", 32'(key_index), 32'(e[3:0]));
            check("held_at_valid", 32'(key_held), 32'd1);
         end
      end
   end

   task automatic wait_pulses(input int target, input int limit, input string name);
      int n = 0;
      while (pulses < target && n < limit) begin
         @(posedge clk);
         n++;
      end
      check(name, 32'(pulses), 32'(target));
   endtask

   task automatic wait_row(input logic [3:0] target);
      int n = 0;
      while (row_drive == target && n < 40) begin @(negedge clk); n++; end
      while (row_drive != target && n < 80) begin @(negedge clk); n++; end
      check("wait_row", 32'(row_drive), 32'(target));
   endtask

   task automatic wait_release(input logic [3:0] exp_row, input string name);
      int n = 0;
      while (key_held !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      check({name, "_held"}, 32'(key_held), 32'd0);
      check({name, "_row"}, 32'(row_drive), 32'(exp_row));
   endtask

   initial begin
      reset = 1'b1;
      kill  = 1'b0;
      for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_key_code", 32'(key_code), 32'd0);
      check("reset_key_index", 32'(key_index), 32'd0);
      check("reset_key_held", 32'(key_held), 32'd0);

      // Idle scan: each row held three cycles
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("idle_row", 32'(row_drive), 32'd1 << ((i / 3) % 4));
      end
      check("idle_no_pulse", 32'(pulses), 32'd0);
      check("idle_key_code", 32'(key_code), 32'd0);

      // Clean press row 0 col 1
      exp_q.push_back({8'b0001_0010, 4'd1});
      keys[0] = 4'b0010;
      wait_pulses(1, 60, "clean_pulse");
      repeat (10) @(negedge clk);
      check("clean_single_pulse", 32'(pulses), 32'd1);
      check("clean_held", 32'(key_held), 32'd1);
      keys[0] = 4'b0000;
      wait_release(4'b0010, "clean_release");
      check("code_kept_after_release", 32'(key_code), 32'h12);

      // Bouncy press row 2 col 3: one-cycle drop inside the debounce window
      wait_row(4'b0100);
      keys[2] = 4'b1000;
      exp_q.push_back({8'b0100_1000, 4'd11});
      repeat (3) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      repeat (6) @(negedge clk);
      check("bounce_no_first_pulse", 32'(pulses), 32'd1);
      wait_pulses(2, 80, "bounce_rescan_pulse");
      @(negedge clk);
      keys[2] = 4'b0000;
      wait_release(4'b1000, "bounce_release");

      // Two columns on row 1: rejected, row advances
      keys[1] = 4'b0101;
      wait_row(4'b0010);
      repeat (3) @(negedge clk);
      check("multi_row_advance", 32'(row_drive), 32'b0100);
      repeat (20) @(negedge clk);
      check("multi_no_pulse", 32'(pulses), 32'd2);
      check("multi_not_held", 32'(key_held), 32'd0);
      keys[1] = 4'b0000;

      // Hold row 0 col 1 then add row 3 col 3
      exp_q.push_back({8'b0001_0010, 4'd1});
      keys[0] = 4'b0010;
      wait_pulses(3, 60, "hold_pulse");
      keys[3] = 4'b1000;
      repeat (30) @(negedge clk);
      check("hold_single_pulse", 32'(pulses), 32'd3);
      check("hold_still_held", 32'(key_held), 32'd1);
      check("hold_code", 32'(key_code), 32'h12);
      check("hold_index", 32'(key_index), 32'd1);
      keys[0] = 4'b0000;
      keys[3] = 4'b0000;
      wait_release(4'b0010, "hold_release");
      exp_q.push_back({8'b1000_1000, 4'd15});
      keys[3] = 4'b1000;
      wait_pulses(4, 60, "r3c3_pulse");
      @(negedge clk);
      keys[3] = 4'b0000;
      wait_release(4'b0001, "r3c3_release");

      // Reset during press debounce of row 3 col 0
      wait_row(4'b1000);
      keys[3] = 4'b0001;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_row_drive", 32'(row_drive), 32'b0001);
      check("rst_key_held", 32'(key_held), 32'd0);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_key_index", 32'(key_index), 32'd0);
      keys[3] = 4'b0000;
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_no_pulse", 32'(pulses), 32'd4);

      // Release bounce: low 2, high 1, then low
      exp_q.push_back({8'b0001_0010, 4'd1});
      keys[0] = 4'b0010;
      wait_pulses(5, 60, "relb_pulse");
      #1 kill = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         kill = (k != 2);
         check("relb_held", 32'(key_held), (k < 9) ? 32'd1 : 32'd0);
      end
      check("relb_row_resume", 32'(row_drive), 32'b0010);
      keys[0] = 4'b0000;
      kill = 1'b0;
      repeat (10) @(negedge clk);
      check("relb_no_second_pulse", 32'(pulses), 32'd5);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
